// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Optional stall counter port enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg #(
    parameter int DATA_W       = 32,
    parameter int CTRL_W       = 4,
    parameter int REG_W        = 5,
    parameter int REGWRITE_BIT = 1,
    parameter int MEMTOREG_BIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_W-1:0]  wreg_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [REG_W-1:0]  wreg_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              haz_regwrite,
    output logic              haz_memtoreg
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // state | meaning
    // EMPTY | main and skid empty
    // ONE   | main holds the output entry, skid empty
    // FULL  | main and skid both hold entries, in_ready low
    // Encoding is {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    localparam int PL_W = CTRL_W + 3*DATA_W + REG_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PL_W-1:0]   r_main_pl;
    logic [PL_W-1:0]   r_skid_pl;
    logic [PL_W-1:0]   w_main_pl_nxt;
    logic [PL_W-1:0]   w_skid_pl_nxt;
    logic [PL_W-1:0]   w_in_pl;
    logic              w_main_vld;
    logic              w_skid_vld;
    logic              w_acc;
    logic              w_drn;
    logic [CTRL_W-1:0] w_m_ctrl;

    assign w_main_vld = r_state[1];
    assign w_skid_vld = r_state[0];
    assign w_in_pl    = {ctrl_i, alu_i, wdata_i, wreg_i, instr_i};

    // in_ready comes straight from the skid valid flop, never from out_ready.
    assign in_ready  = ~w_skid_vld;
    assign out_valid = w_main_vld;
    assign w_acc     = in_valid & ~w_skid_vld;
    assign w_drn     = w_main_vld & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_main_pl <= '0;
            r_skid_pl <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_main_pl <= w_main_pl_nxt;
            r_skid_pl <= w_skid_pl_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_main_pl_nxt = r_main_pl;
        w_skid_pl_nxt = r_skid_pl;
        if (flush) begin
            w_state_nxt   = ST_EMPTY;
            w_main_pl_nxt = '0;
            w_skid_pl_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt   = ST_ONE;
                        w_main_pl_nxt = w_in_pl;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_drn) begin
                        w_main_pl_nxt = w_in_pl;
                    end else if (w_acc) begin
                        w_state_nxt   = ST_FULL;
                        w_skid_pl_nxt = w_in_pl;
                    end else if (w_drn) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drn) begin
                        w_state_nxt   = ST_ONE;
                        w_main_pl_nxt = r_skid_pl;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign {w_m_ctrl, alu_o, wdata_o, wreg_o, instr_o} = r_main_pl;

    // Bubbles must not look like live control to the hazard unit.
    assign ctrl_o       = w_main_vld ? w_m_ctrl : '0;
    assign haz_regwrite = ctrl_o[REGWRITE_BIT];
    assign haz_memtoreg = ctrl_o[MEMTOREG_BIT];

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_main_vld && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard of held entries.
// Stall counter checks run only when PIPE_STAGE_STALL_CNT_EN is defined.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl_i;
    logic [31:0] alu_i;
    logic [31:0] wdata_i;
    logic [4:0]  wreg_i;
    logic [31:0] instr_i;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ctrl_o;
    logic [31:0] alu_o;
    logic [31:0] wdata_o;
    logic [4:0]  wreg_o;
    logic [31:0] instr_o;
    logic        haz_regwrite;
    logic        haz_memtoreg;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    ent_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_stall = 16'd0;

    pipe_stage_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ctrl_i       (ctrl_i),
        .alu_i        (alu_i),
        .wdata_i      (wdata_i),
        .wreg_i       (wreg_i),
        .instr_i      (instr_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ctrl_o       (ctrl_o),
        .alu_o        (alu_o),
        .wdata_o      (wdata_o),
        .wreg_o       (wreg_o),
        .instr_o      (instr_o),
        .haz_regwrite (haz_regwrite),
        .haz_memtoreg (haz_memtoreg)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] w, input logic [4:0] r, input logic [31:0] ins);
        in_valid = v;
        ctrl_i   = c;
        alu_i    = a;
        wdata_i  = w;
        wreg_i   = r;
        instr_i  = ins;
    endtask

    // Called at a negedge with inputs already set: check outputs against the
    // scoreboard, update it for the coming edge, then advance one cycle.
    task automatic step();
        ent_t e;
        logic exp_v;
        exp_v = (q.size() != 0);
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
        chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
        if (exp_v) begin
            e = q[0];
            chk("ctrl_o", {60'd0, ctrl_o}, {60'd0, e.ctrl});
            chk("alu_o", {32'd0, alu_o}, {32'd0, e.alu});
            chk("wdata_o", {32'd0, wdata_o}, {32'd0, e.wdata});
            chk("wreg_o", {59'd0, wreg_o}, {59'd0, e.wreg});
            chk("instr_o", {32'd0, instr_o}, {32'd0, e.instr});
            chk("haz_regwrite", {63'd0, haz_regwrite}, {63'd0, e.ctrl[1]});
            chk("haz_memtoreg", {63'd0, haz_memtoreg}, {63'd0, e.ctrl[2]});
        end else begin
            chk("ctrl_o_bubble", {60'd0, ctrl_o}, 64'd0);
            chk("haz_bubble", {62'd0, haz_regwrite, haz_memtoreg}, 64'd0);
        end
        if (exp_v && !out_ready && exp_stall != 16'hFFFF)
            exp_stall++;
        if (exp_v && out_ready)
            void'(q.pop_front());
        if (in_valid && (q.size() < 2) && !(exp_v && !out_ready && q.size() == 2))
            q.push_back('{ctrl: ctrl_i, alu: alu_i, wdata: wdata_i, wreg: wreg_i, instr: instr_i});
        if (flush)
            q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_payload", {ctrl_o, alu_o[19:0], wreg_o, instr_o[7:0], haz_regwrite, haz_memtoreg}, 64'd0);
        rst_n = 1'b1;

        // Streaming with out_ready high: one entry per cycle, 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'b0110, i, 32'h100 + i, 5'(i), 32'hA000 + i);
            step();
        end
        drive(1'b0, 4'b0110, 32'd0, 32'd0, 5'd0, 32'd0);
        chk("stream_last_alu", {32'd0, alu_o}, 64'd4);
        step();
        step();

        // Back-pressure: two entries fill main and skid.
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd5, 32'd55, 5'd3, 32'h5);
        step();
        drive(1'b1, 4'b0100, 32'd6, 32'd66, 5'd4, 32'h6);
        step();
        drive(1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 32'd0);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        out_ready = 1'b1;
        chk("bp_first", {32'd0, alu_o}, 64'd5);
        step();
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        chk("bp_second", {32'd0, alu_o}, 64'd6);
        step();
        step();

        // Flush in FULL with a live input; nothing may survive.
        out_ready = 1'b0;
        drive(1'b1, 4'b0110, 32'd7, 32'd0, 5'd7, 32'h7);
        step();
        drive(1'b1, 4'b0110, 32'd8, 32'd0, 5'd8, 32'h8);
        step();
        drive(1'b1, 4'b1111, 32'd9, 32'd9, 5'd9, 32'hDEADBEEF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 32'd0);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_instr_o", {32'd0, instr_o}, 64'd0);
        chk("flush_alu_o", {32'd0, alu_o}, 64'd0);

        // Flush in ONE while accepting: the incoming entry is dropped too.
        drive(1'b1, 4'b0010, 32'd10, 32'd0, 5'd10, 32'h10);
        step();
        drive(1'b1, 4'b0110, 32'd11, 32'd0, 5'd11, 32'hDEADBEEF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 32'd0);
        step();
        step();

        // Bubble masking with ctrl_i all ones and no valid input.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'hF, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'd1);
            step();
        end

        // Asynchronous reset while holding an entry.
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd12, 32'd0, 5'd17, 32'h12);
        step();
        drive(1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 32'd0);
        chk("pre_rst_wreg", {59'd0, wreg_o}, 64'd17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wreg", {59'd0, wreg_o}, 64'd0);
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        q.delete();
        exp_stall = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("stall_after_rst", {48'd0, stall_cnt}, 64'd0);
        drive(1'b1, 4'b0010, 32'd13, 32'd0, 5'd13, 32'h13);
        step();
        drive(1'b0, 4'h0, 32'd0, 32'd0, 5'd0, 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("stall_10", {48'd0, stall_cnt}, 64'd10);
        chk("stall_model", {48'd0, stall_cnt}, {48'd0, exp_stall});
        for (int i = 0; i < 65524; i++) step();
        chk("stall_fffe", {48'd0, stall_cnt}, 64'hFFFE);
        for (int i = 0; i < 5; i++) step();
        chk("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stall_kept_by_flush", {48'd0, stall_cnt}, 64'hFFFF);
`endif

        out_ready = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
